multiport_register_file: RTL and testbench
==========================================

# multiport_register_file

Parametrised multi-port register file with independent read and write ports, binary addressing, per-byte write enables, registered reads with same-cycle write bypass, and per-register dirty tracking. It is the general storage primitive for generated cache and controller datapaths (tag/state arrays, configuration banks) where the port count, width and depth come from the generator. All packed vectors are big-endian ascending (`[0:N-1]`); port `p` occupies slice `[p*W : (p+1)*W-1]` of its bus.

## Interface
- `DATA_WIDTH`, 32, bits per register; must be a multiple of 8.
- `NUM_REGISTERS`, 8, register count; must be ≥ 2.
- `READ_PORTS`, 2, number of read ports; must be ≥ 1.
- `WRITE_PORTS`, 2, number of write ports; must be ≥ 1.
- Derived: `ADDR_WIDTH` = `$clog2(NUM_REGISTERS)`; `BYTES` = `DATA_WIDTH/8`.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_n_i`  in  1  reset; one clock, and reset is asynchronous and active-low.
- `read_en_i`  in  `READ_PORTS`  per-port read request.
- `read_addr_i`  in  `READ_PORTS*ADDR_WIDTH`  per-port binary read address.
- `read_data_o`  out  `READ_PORTS*DATA_WIDTH`  per-port registered read data.
- `read_valid_o`  out  `READ_PORTS`  per-port read data valid, one cycle after the request.
- `write_en_i`  in  `WRITE_PORTS`  per-port write request.
- `write_addr_i`  in  `WRITE_PORTS*ADDR_WIDTH`  per-port binary write address.
- `write_data_i`  in  `WRITE_PORTS*DATA_WIDTH`  per-port write data.
- `write_byte_en_i`  in  `WRITE_PORTS*BYTES`  per-port byte enables; bit 0 of a port's slice is byte `[0:7]`.
- `dirty_clear_i`  in  `NUM_REGISTERS`  per-register dirty clear.
- `dirty_o`  out  `NUM_REGISTERS`  per-register dirty flag.
- `addr_error_o`  out  1  registered pulse: an enabled port used an address ≥ `NUM_REGISTERS` in the previous cycle.

## Operation
- Reset (asserted): all registers = 0, `read_data_o` = 0, `read_valid_o` = 0, `dirty_o` = 0, `addr_error_o` = 0. The reset is asynchronous, so assertion mid-operation clears state immediately and any write in flight is lost. Operation resumes on the first rising edge after deassertion.
- Write: on a rising edge, each enabled, in-range port updates only its enabled bytes of `registers[write_addr]`.
- Write collisions: when several ports write the same byte lane of the same register, the highest-numbered port wins, resolved per byte. Lanes written by only one port merge normally.
- Out-of-range write: ignored and sets `addr_error_o` on the next cycle.
- A write with all byte enables 0 is a no-op and does not set the dirty flag.
- Read: if `read_en_i[p]` is set and the address is in range, `read_data_o[p]` and `read_valid_o[p]` = 1 are loaded on the edge. If `read_en_i[p]` = 0, `read_data_o[p]` holds its value and `read_valid_o[p]` = 0.
- Out-of-range read: loads 0, sets `read_valid_o[p]` = 0, and sets `addr_error_o` on the next cycle.
- Bypass: a read and a write to the same address in the same cycle return the post-write value, meaning all byte merges and collision priority are applied. Old data is never returned.
- Dirty: `dirty_o[r]` is set by any effective write to `r` and cleared by `dirty_clear_i[r]`. Set wins over a simultaneous clear.
- Any number of ports may access the same register in the same cycle; there are no stalls and no back-pressure.

## Timing
- Read latency is 1 cycle, request to `read_data_o`/`read_valid_o`.
- Write-to-storage latency is 1 edge. A read issued in the cycle after a write sees the new data via storage, and a read issued in the same cycle sees it via the bypass.
- `dirty_o` and `addr_error_o` update on the same edge as the write they reflect; `addr_error_o` is high for exactly one cycle per offending cycle.
- No combinational path from any input to any output.

## Test plan
- **Reset:** write 0xDEADBEEF to r3, then assert `reset_n_i` mid-cycle → `dirty_o` = 0 and `read_data_o` = 0 immediately, without waiting for a clock edge; a subsequent read of r3 returns 0x00000000 with valid = 1.
- **Byte merge and collision:** r2 = 0x11223344. Port 0 writes 0xAAAAAAAA with byte_en 1100 and port 1 writes 0xBBBBBBBB with byte_en 0110 in the same cycle → read r2 = 0xAABBBB44.
- **Bypass:** port 0 reads r5 while port 1 writes 0x12345678 (all bytes) to r5 in the same cycle → next cycle `read_data_o[0]` = 0x12345678 with valid = 1.
- **Hold:** `read_en_i` = 0 for 3 cycles after a read of 0xCAFEF00D → data holds 0xCAFEF00D and valid = 0 for those cycles.
- **Dirty:** write r1 while asserting `dirty_clear_i[1]` → `dirty_o[1]` = 1. The next cycle, assert clear alone → `dirty_o[1]` = 0. A write with byte_en 0000 → `dirty_o[1]` stays 0.
- **Out-of-range:** with `NUM_REGISTERS` = 6, write address 7 and read address 6 → storage unchanged, `read_valid_o` = 0, `read_data_o` = 0, and `addr_error_o` = 1 for exactly one cycle.

Source files
------------

// File: rtl/multiport_register_file.sv
// Multi-port register file with registered reads and same-cycle write bypass.
// It also provides per-byte write enables, per-register dirty tracking and an
// out-of-range address error pulse.
// Buses are ascending ([0:N-1]). Port p owns slice [p*W : (p+1)*W-1].
// Byte 0 of a word is bits [0:7].
// DATA_WIDTH must be a multiple of 8.
// NUM_REGISTERS must be >= 2.
// READ_PORTS and WRITE_PORTS must each be >= 1.
module multiport_register_file #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 8,
   parameter int READ_PORTS    = 2,
   parameter int WRITE_PORTS   = 2,
   localparam int ADDR_WIDTH   = $clog2(NUM_REGISTERS),
   localparam int BYTES        = DATA_WIDTH / 8
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic [0:READ_PORTS-1]               read_en_i,
   input  logic [0:READ_PORTS*ADDR_WIDTH-1]    read_addr_i,
   output logic [0:READ_PORTS*DATA_WIDTH-1]    read_data_o,
   output logic [0:READ_PORTS-1]               read_valid_o,
   input  logic [0:WRITE_PORTS-1]              write_en_i,
   input  logic [0:WRITE_PORTS*ADDR_WIDTH-1]   write_addr_i,
   input  logic [0:WRITE_PORTS*DATA_WIDTH-1]   write_data_i,
   input  logic [0:WRITE_PORTS*BYTES-1]        write_byte_en_i,
   input  logic [0:NUM_REGISTERS-1]            dirty_clear_i,
   output logic [0:NUM_REGISTERS-1]            dirty_o,
   output logic                                addr_error_o
);

   // Per-port address decode.
   logic [ADDR_WIDTH-1:0] waddr [WRITE_PORTS];
   logic [ADDR_WIDTH-1:0] raddr [READ_PORTS];
   logic [0:WRITE_PORTS-1] wr_in_range;
   logic [0:READ_PORTS-1]  rd_in_range;

   // Storage, and the post-write value of every register for this cycle.
   logic [0:DATA_WIDTH-1]  regs   [NUM_REGISTERS];
   logic [0:DATA_WIDTH-1]  merged [NUM_REGISTERS];
   logic [0:NUM_REGISTERS-1] written;

   logic [0:READ_PORTS*DATA_WIDTH-1] rd_data_next;
   logic [0:READ_PORTS-1]            rd_valid_next;
   logic                             addr_error_next;

   genvar gi;
   generate
      for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_wdec
         assign waddr[gi]       = write_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wr_in_range[gi] = (32'(waddr[gi]) < NUM_REGISTERS);
      end
      for (gi = 0; gi < READ_PORTS; gi++) begin : g_rdec
         assign raddr[gi]       = read_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign rd_in_range[gi] = (32'(raddr[gi]) < NUM_REGISTERS);
      end
   endgenerate

   // Merge all write ports into each register.
   // Ports are applied in ascending order, so on a shared byte lane the
   // highest-numbered port overwrites the others.
   always_comb begin
      for (int r = 0; r < NUM_REGISTERS; r++) begin
         merged[r]  = regs[r];
         written[r] = 1'b0;
         for (int p = 0; p < WRITE_PORTS; p++) begin
            if (write_en_i[p] && wr_in_range[p] && waddr[p] == ADDR_WIDTH'(r)) begin
               for (int b = 0; b < BYTES; b++) begin
                  if (write_byte_en_i[p*BYTES + b]) begin
                     merged[r][b*8 +: 8] = write_data_i[p*DATA_WIDTH + b*8 +: 8];
                     written[r]          = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Read mux.
   // Reads select the merged (post-write) value, which provides the bypass.
   // An idle port keeps its previous data.
   always_comb begin
      rd_data_next  = read_data_o;
      rd_valid_next = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         if (read_en_i[p]) begin
            rd_data_next[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            if (rd_in_range[p]) begin
               rd_valid_next[p] = 1'b1;
               for (int r = 0; r < NUM_REGISTERS; r++) begin
                  if (raddr[p] == ADDR_WIDTH'(r)) begin
                     rd_data_next[p*DATA_WIDTH +: DATA_WIDTH] = merged[r];
                  end
               end
            end
         end
      end
   end

   // Flag any enabled port, read or write, that addresses past the last register.
   always_comb begin
      addr_error_next = (|(read_en_i & ~rd_in_range)) | (|(write_en_i & ~wr_in_range));
   end

   // Storage update; every register takes its merged value.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            regs[r] <= merged[r];
         end
      end
   end

   // Output registers: read data/valid, dirty flags (set beats clear), error pulse.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         read_data_o  <= '0;
         read_valid_o <= '0;
         dirty_o      <= '0;
         addr_error_o <= 1'b0;
      end else begin
         read_data_o  <= rd_data_next;
         read_valid_o <= rd_valid_next;
         dirty_o      <= written | (dirty_o & ~dirty_clear_i);
         addr_error_o <= addr_error_next;
      end
   end

endmodule

// File: tb/tb_multiport_register_file.sv
// Testbench for multiport_register_file.
// A table of single-cycle vectors is checked through a scoreboard queue.
// Hand-written sequences then cover hold, dirty, async reset and out-of-range
// accesses (the latter on a 6-register instance).
module tb_multiport_register_file;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int AW = 3;
   localparam int BY = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n = 1'b0;

   // Default instance (8 registers).
   logic [0:1]      read_en = '0;
   logic [0:2*AW-1] read_addr = '0;
   logic [0:2*DW-1] read_data;
   logic [0:1]      read_valid;
   logic [0:1]      write_en = '0;
   logic [0:2*AW-1] write_addr = '0;
   logic [0:2*DW-1] write_data = '0;
   logic [0:2*BY-1] write_be = '0;
   logic [0:NR-1]   dirty_clear = '0;
   logic [0:NR-1]   dirty;
   logic            addr_error;

   // Six-register instance for out-of-range addressing.
   logic [0:1]      s_read_en = '0;
   logic [0:2*AW-1] s_read_addr = '0;
   logic [0:2*DW-1] s_read_data;
   logic [0:1]      s_read_valid;
   logic [0:1]      s_write_en = '0;
   logic [0:2*AW-1] s_write_addr = '0;
   logic [0:2*DW-1] s_write_data = '0;
   logic [0:2*BY-1] s_write_be = '0;
   logic [0:5]      s_dirty_clear = '0;
   logic [0:5]      s_dirty;
   logic            s_addr_error;

   multiport_register_file dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .read_en_i(read_en), .read_addr_i(read_addr),
      .read_data_o(read_data), .read_valid_o(read_valid),
      .write_en_i(write_en), .write_addr_i(write_addr),
      .write_data_i(write_data), .write_byte_en_i(write_be),
      .dirty_clear_i(dirty_clear), .dirty_o(dirty), .addr_error_o(addr_error)
   );

   multiport_register_file #(.NUM_REGISTERS(6)) dut6 (
      .clk_i(clk), .reset_n_i(reset_n),
      .read_en_i(s_read_en), .read_addr_i(s_read_addr),
      .read_data_o(s_read_data), .read_valid_o(s_read_valid),
      .write_en_i(s_write_en), .write_addr_i(s_write_addr),
      .write_data_i(s_write_data), .write_byte_en_i(s_write_be),
      .dirty_clear_i(s_dirty_clear), .dirty_o(s_dirty), .addr_error_o(s_addr_error)
   );

   typedef struct {
      logic        we0, we1;
      logic [2:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [3:0]  be0, be1;
      logic        re0, re1;
      logic [2:0]  ra0, ra1;
      logic [0:7]  clr;
      logic [31:0] ed0, ed1;
      logic        ev0, ev1;
      logic [0:7]  edirty;
   } vec_t;

   typedef struct {
      logic [31:0] d0, d1;
      logic        v0, v1;
      logic [0:7]  dirty;
      logic        err;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];
   int total = 0;
   int bad = 0;

   function automatic vec_t mk(
      input logic we0, input logic [2:0] wa0, input logic [31:0] wd0, input logic [3:0] be0,
      input logic we1, input logic [2:0] wa1, input logic [31:0] wd1, input logic [3:0] be1,
      input logic re0, input logic [2:0] ra0, input logic re1, input logic [2:0] ra1,
      input logic [0:7] clr,
      input logic [31:0] ed0, input logic ev0, input logic [31:0] ed1, input logic ev1,
      input logic [0:7] edirty);
      vec_t v;
      v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0; v.be0 = be0;
      v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1; v.be1 = be1;
      v.re0 = re0; v.ra0 = ra0; v.re1 = re1; v.ra1 = ra1;
      v.clr = clr;
      v.ed0 = ed0; v.ev0 = ev0; v.ed1 = ed1; v.ev1 = ev1;
      v.edirty = edirty;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      read_en = '0; write_en = '0; write_be = '0; dirty_clear = '0;
      s_read_en = '0; s_write_en = '0; s_write_be = '0; s_dirty_clear = '0;
   endtask

   task automatic apply(input int idx);
      vec_t v;
      exp_t e;
      exp_t got;
      v = vecs[idx];
      write_en   = {v.we0, v.we1};
      write_addr = {v.wa0, v.wa1};
      write_data = {v.wd0, v.wd1};
      write_be   = {v.be0, v.be1};
      read_en    = {v.re0, v.re1};
      read_addr  = {v.ra0, v.ra1};
      dirty_clear = v.clr;
      e.d0 = v.ed0; e.d1 = v.ed1; e.v0 = v.ev0; e.v1 = v.ev1;
      e.dirty = v.edirty; e.err = 1'b0;
      sb.push_back(e);
      tick();
      got = sb.pop_front();
      $display("vec %0d: d0=%h v0=%b d1=%h v1=%b dirty=%b err=%b", idx,
               read_data[0:31], read_valid[0], read_data[32:63], read_valid[1], dirty, addr_error);
      check($sformatf("vec%0d data0", idx), 64'(read_data[0:31]), 64'(got.d0));
      check($sformatf("vec%0d valid0", idx), 64'(read_valid[0]), 64'(got.v0));
      check($sformatf("vec%0d data1", idx), 64'(read_data[32:63]), 64'(got.d1));
      check($sformatf("vec%0d valid1", idx), 64'(read_valid[1]), 64'(got.v1));
      check($sformatf("vec%0d dirty", idx), 64'(dirty), 64'(got.dirty));
      check($sformatf("vec%0d addr_error", idx), 64'(addr_error), 64'(got.err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Vector table. Dirty columns are r0..r7 from left to right.
      vecs[0] = mk(1,2,32'h11223344,4'b1111, 0,0,32'h0,4'b0000, 1,2, 1,0, 8'b0000_0000,
                   32'h11223344,1, 32'h00000000,1, 8'b0010_0000);
      vecs[1] = mk(1,2,32'hAAAAAAAA,4'b1100, 1,2,32'hBBBBBBBB,4'b0110, 0,0, 1,2, 8'b0000_0000,
                   32'h11223344,0, 32'hAABBBB44,1, 8'b0010_0000);
      vecs[2] = mk(0,0,32'h0,4'b0000, 0,0,32'h0,4'b0000, 1,2, 1,7, 8'b0000_0000,
                   32'hAABBBB44,1, 32'h00000000,1, 8'b0010_0000);
      vecs[3] = mk(0,0,32'h0,4'b0000, 1,5,32'h12345678,4'b1111, 1,5, 0,0, 8'b0000_0000,
                   32'h12345678,1, 32'h00000000,0, 8'b0010_0100);
      vecs[4] = mk(1,6,32'h55555555,4'b1111, 1,6,32'h66666666,4'b0011, 1,5, 1,6, 8'b0000_0000,
                   32'h12345678,1, 32'h55556666,1, 8'b0010_0110);
      vecs[5] = mk(1,1,32'hDEADBEEF,4'b1001, 1,3,32'hFFFFFFFF,4'b0000, 1,1, 1,3, 8'b0010_0100,
                   32'hDE0000EF,1, 32'h00000000,1, 8'b0100_0010);
      vecs[6] = mk(0,0,32'h0,4'b0000, 0,0,32'h0,4'b0000, 0,0, 0,0, 8'b0000_0000,
                   32'hDE0000EF,0, 32'h00000000,0, 8'b0100_0010);
      vecs[7] = mk(0,0,32'h0,4'b0000, 1,1,32'h000000AA,4'b0001, 1,6, 1,1, 8'b0100_0010,
                   32'h55556666,1, 32'hDE0000AA,1, 8'b0100_0000);

      // Reset state while reset is held.
      tick(); tick();
      check("reset data", 64'(read_data), 64'h0);
      check("reset valid", 64'(read_valid), 64'h0);
      check("reset dirty", 64'(dirty), 64'h0);
      check("reset addr_error", 64'(addr_error), 64'h0);
      check("reset6 valid", 64'(s_read_valid), 64'h0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) apply(i);
      idle();

      // Hold: data stays after a read while read_en is low.
      write_en = 2'b10; write_addr[0:2] = 3'd4; write_data[0:31] = 32'hCAFEF00D; write_be[0:3] = 4'b1111;
      tick();
      idle();
      read_en = 2'b10; read_addr[0:2] = 3'd4;
      tick();
      $display("hold read: d0=%h v0=%b", read_data[0:31], read_valid[0]);
      check("hold first data", 64'(read_data[0:31]), 64'hCAFEF00D);
      check("hold first valid", 64'(read_valid[0]), 64'h1);
      idle();
      for (int c = 0; c < 3; c++) begin
         tick();
         $display("hold cycle %0d: d0=%h v0=%b", c, read_data[0:31], read_valid[0]);
         check($sformatf("hold%0d data", c), 64'(read_data[0:31]), 64'hCAFEF00D);
         check($sformatf("hold%0d valid", c), 64'(read_valid[0]), 64'h0);
      end

      // Dirty: clear r1, then write+clear (set wins), clear alone, empty write.
      dirty_clear = 8'b0100_0000;
      tick();
      $display("dirty clear: dirty=%b", dirty);
      check("dirty pre-clear r1", 64'(dirty[1]), 64'h0);
      dirty_clear = 8'b0100_0000;
      write_en = 2'b01; write_addr[3:5] = 3'd1; write_data[32:63] = 32'h0000_0001; write_be[4:7] = 4'b1111;
      tick();
      $display("dirty write+clear: dirty=%b", dirty);
      check("dirty set wins", 64'(dirty[1]), 64'h1);
      idle();
      dirty_clear = 8'b0100_0000;
      tick();
      $display("dirty clear alone: dirty=%b", dirty);
      check("dirty cleared", 64'(dirty[1]), 64'h0);
      idle();
      write_en = 2'b10; write_addr[0:2] = 3'd1; write_data[0:31] = 32'hFFFFFFFF; write_be[0:3] = 4'b0000;
      tick();
      $display("dirty empty write: dirty=%b", dirty);
      check("dirty no-op write", 64'(dirty[1]), 64'h0);
      idle();
      read_en = 2'b10; read_addr[0:2] = 3'd1;
      tick();
      check("no-op write data", 64'(read_data[0:31]), 64'h00000001);

      // Asynchronous reset mid-cycle.
      idle();
      write_en = 2'b10; write_addr[0:2] = 3'd3; write_data[0:31] = 32'hDEADBEEF; write_be[0:3] = 4'b1111;
      read_en = 2'b10; read_addr[0:2] = 3'd3;
      tick();
      check("pre-reset data", 64'(read_data[0:31]), 64'hDEADBEEF);
      check("pre-reset dirty r3", 64'(dirty[3]), 64'h1);
      idle();
      #2 reset_n = 1'b0;
      #1;
      $display("async reset: data=%h valid=%b dirty=%b", read_data, read_valid, dirty);
      check("async reset dirty", 64'(dirty), 64'h0);
      check("async reset data", 64'(read_data), 64'h0);
      check("async reset valid", 64'(read_valid), 64'h0);
      tick();
      reset_n = 1'b1;
      read_en = 2'b10; read_addr[0:2] = 3'd3;
      tick();
      $display("post-reset read r3: d0=%h v0=%b", read_data[0:31], read_valid[0]);
      check("post-reset r3 data", 64'(read_data[0:31]), 64'h00000000);
      check("post-reset r3 valid", 64'(read_valid[0]), 64'h1);
      idle();

      // Out-of-range on the 6-register instance.
      s_write_en = 2'b10; s_write_addr[0:2] = 3'd2; s_write_data[0:31] = 32'h0BADCAFE; s_write_be[0:3] = 4'b1111;
      s_read_en = 2'b10; s_read_addr[0:2] = 3'd2;
      tick();
      check("oor setup data", 64'(s_read_data[0:31]), 64'h0BADCAFE);
      check("oor setup err", 64'(s_addr_error), 64'h0);
      idle();
      s_write_en = 2'b10; s_write_addr[0:2] = 3'd7; s_write_data[0:31] = 32'hFFFFFFFF; s_write_be[0:3] = 4'b1111;
      s_read_en = 2'b10; s_read_addr[0:2] = 3'd6;
      tick();
      $display("oor access: d0=%h v0=%b err=%b dirty=%b", s_read_data[0:31], s_read_valid[0], s_addr_error, s_dirty);
      check("oor read valid", 64'(s_read_valid[0]), 64'h0);
      check("oor read data", 64'(s_read_data[0:31]), 64'h0);
      check("oor addr_error", 64'(s_addr_error), 64'h1);
      check("oor dirty", 64'(s_dirty), 64'(6'b001000));
      idle();
      s_read_en = 2'b11; s_read_addr = {3'd2, 3'd5};
      tick();
      $display("oor after: d0=%h d1=%h err=%b", s_read_data[0:31], s_read_data[32:63], s_addr_error);
      check("oor error one cycle", 64'(s_addr_error), 64'h0);
      check("oor r2 unchanged", 64'(s_read_data[0:31]), 64'h0BADCAFE);
      check("oor r5 unchanged", 64'(s_read_data[32:63]), 64'h0);
      check("oor reads valid", 64'(s_read_valid), 64'h3);
      idle();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
